div_unit: RTL



---
 rtl/div_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle.
module div_unit (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [1:0]  op_q;
  logic        qsign_q;
  logic        rsign_q;
  logic [32:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dvsr_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;

  logic        accept;
  logic        zero_fast;
  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        qsign_in;
  logic        rsign_in;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        take;
  logic [32:0] rem_nx;
  logic [31:0] quot_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] res_fin;
  logic [31:0] res_zero;
  logic        last;

  // A new request is taken only when idle or finishing, and never on flush
  assign accept = start_i & ~flush_i & (state_q != CALC);
  assign last   = (cnt_q == 5'd31);

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (divisor_i == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  // Operand conditioning: magnitudes and result signs
  assign signed_op = ~op_i[0];
  assign a_mag     = (signed_op & dividend_i[31]) ? (~dividend_i + 32'd1)
                                                  : dividend_i;
  assign b_mag     = (signed_op & divisor_i[31]) ? (~divisor_i + 32'd1)
                                                 : divisor_i;
  assign qsign_in  = signed_op & (dividend_i[31] ^ divisor_i[31])
                   & (divisor_i != 32'd0);
  assign rsign_in  = signed_op & dividend_i[31];
  assign res_zero  = op_i[1] ? dividend_i : 32'hFFFF_FFFF;

  // One restoring step: shift in the next dividend bit, trial subtract
  assign rem_sh  = {rem_q[31:0], quot_q[31]};
  assign trial   = rem_sh - {1'b0, dvsr_q};
  assign take    = rem_q[32] | ~trial[32];
  assign rem_nx  = take ? trial : rem_sh;
  assign quot_nx = {quot_q[30:0], take};

  // Final sign fix-up of the selected result
  assign q_fin   = qsign_q ? (~quot_nx + 32'd1) : quot_nx;
  assign r_fin   = rsign_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
  assign res_fin = op_q[1] ? r_fin : q_fin;

  // State and registered status flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Next-state selection; flush overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = zero_fast ? DONE : CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (accept) state_d = zero_fast ? DONE : CALC;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Status flags follow the state being entered
  always_comb begin
    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

  // Datapath: operand capture, iteration and result latch
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q     <= 2'd0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      rem_q    <= 33'd0;
      quot_q   <= 32'd0;
      dvsr_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else if (accept) begin
      op_q    <= op_i;
      qsign_q <= qsign_in;
      rsign_q <= rsign_in;
      rem_q   <= 33'd0;
      quot_q  <= a_mag;
      dvsr_q  <= b_mag;
      cnt_q   <= 5'd0;
      if (zero_fast) result_q <= res_zero;
    end else if (state_q == CALC) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      cnt_q  <= cnt_q + 5'd1;
      if (last && !flush_i) result_q <= res_fin;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule
